mux32_4x1_arbiter: RTL
======================

Name: mux32_4x1_arbiter

Overview:
Round-robin arbiter sharing one 32-bit 4-to-1 datapath mux among four requesters. Each requester holds its word on its own input port (I0..I3) and raises REQ. The block grants one owner at a time, drives the mux select, and presents the owner's word on a registered output with a valid flag. A hold limit stops any owner from starving the others; it sits between the processor's bus masters and the shared 32-bit bus.

Parameters:
MAX_HOLD, 8, max consecutive cycles an owner keeps the grant while another REQ is pending (legal 1..15)
CNT_W, 4, hold-counter width (must hold MAX_HOLD-1)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
REQ  input  4  request per requester, bit i = requester i
I0   input  32  data word of requester 0
I1   input  32  data word of requester 1
I2   input  32  data word of requester 2
I3   input  32  data word of requester 3
GNT  output 4  one-hot grant, registered, all-zero when idle
S    output 2  select driven into the mux, registered, equals index of GNT bit
Y    output 32  registered shared-bus data
VALID output 1  Y holds a granted requester's word

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, GNT=0000, S=0, Y=0, VALID=0, hold count=0, RR pointer=0; RST overrides all other inputs, including mid-grant.
- Round-robin pick: search REQ starting at index PTR, ascending, wrapping 3->0; first set bit wins. After granting i, PTR=(i+1) mod 4.
- IDLE: if REQ!=0 at edge -> GRANT, GNT=onehot(pick), S=pick, count=0. Otherwise stay IDLE, GNT=0.
- GRANT, owner o:
  - Release: REQ[o]=0 at edge -> re-arbitrate that same edge over REQ (o's bit is 0). Any winner -> GRANT to it, count=0, no idle bubble. None -> IDLE, GNT=0.
  - Timeout: REQ[o]=1, count==MAX_HOLD-1, and some other REQ bit set -> grant next requester after o in RR order, count=0.
  - Timeout with no other requester: o keeps grant, count resets to 0.
  - Otherwise: hold, count+=1 (saturates, never wraps).
- Data path: Y <= mux(I0..I3, S) and VALID <= 1 at every edge where state==GRANT and REQ[owner]=1; else Y <= Y (held), VALID <= 0.
- Latency: REQ high at edge n -> GNT/S valid after edge n -> Y/VALID after edge n+1. Word sampled is I[S] at edge n+1.
- Owner's input word may change every cycle while granted; Y tracks it with 1-cycle lag.
- Simultaneous REQ rise on several lines: RR pointer decides; never more than one GNT bit set.
- GNT and S always consistent; S is only meaningful when GNT!=0 but holds last value when idle.

Decomposition:
- Shared package/defines file: state encodings (IDLE=1'b0, GRANT=1'b1), REQ/GNT width 4, data width 32.
- One sub-module: the existing 32-bit 4x1 mux, instantiated once as the datapath. Select comes from S; output feeds the Y register.
- Arbitration pick (rotating priority encoder) stays inline as combinational logic.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=1111 -> GNT=0000, S=0, Y=0, VALID=0. Deassert -> GNT=0001 next cycle.
- Single requester: I2=1431655702, REQ=0100 -> GNT=0100, S=2 after 1 cycle. Y=1431655702, VALID=1 after 2 cycles. Drop REQ -> GNT=0000, VALID=0.
- Round-robin: I0..I3=1431655700..1431655703, REQ=1111 toggled per owner release -> grant order 0,1,2,3,0. Y values in same order, no idle cycles between owners.
- Hold timeout: MAX_HOLD=8, REQ=0011 held -> owner 0 for 8 cycles, then GNT=0010. Same test with REQ=0001 -> owner 0 never loses grant.
- Wrap/pointer: last grant 3, then REQ=1001 -> GNT=0001 (pointer wrapped to 0), not 1000.
- Reset mid-grant: owner 1 granted, Y=1431655701, RST=1 one cycle -> all outputs zero next edge. Regrant follows from PTR=0.

Source files
------------

// File: rtl/mux32_4x1_arbiter_pkg.sv
// Shared definitions for the round-robin 4-requester 32-bit bus arbiter.
package mux32_4x1_arbiter_pkg;

    localparam int REQ_W  = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Rotating priority encoder: first set bit of req at or after start, wrapping 3->0.
    // The loop runs from the farthest offset down so the nearest candidate is written last and wins.
    function automatic pick_t rr_pick(input logic [REQ_W-1:0] req, input logic [SEL_W-1:0] start);
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = start;
        for (int k = REQ_W - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [REQ_W-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [REQ_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux32_4x1_arbiter_mux.sv
// Plain 32-bit 4-to-1 datapath multiplexer shared by the four bus masters.
module mux32_4x1_arbiter_mux
    import mux32_4x1_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic [DATA_W-1:0] out
);

    // Select one requester's word; purely combinational.
    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/mux32_4x1_arbiter.sv
// Round-robin arbiter owning one shared 32-bit 4:1 mux, with a hold limit that
// keeps a long-running owner from starving other requesters.
module mux32_4x1_arbiter
    import mux32_4x1_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REQ_W-1:0]  REQ,
    input  logic [DATA_W-1:0] I0,
    input  logic [DATA_W-1:0] I1,
    input  logic [DATA_W-1:0] I2,
    input  logic [DATA_W-1:0] I3,
    output logic [REQ_W-1:0]  GNT,
    output logic [SEL_W-1:0]  S,
    output logic [DATA_W-1:0] Y,
    output logic              VALID
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t             state_q, state_d;
    logic [REQ_W-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  y_q, y_d;
    logic               valid_q, valid_d;

    logic [DATA_W-1:0]  mux_y;
    pick_t              pick_ptr;
    pick_t              pick_other;
    logic               owner_req;

    // The mux select is the registered S, so the word captured is the owner's current input.
    mux32_4x1_arbiter_mux u_mux (
        .sel (s_q),
        .in0 (I0),
        .in1 (I1),
        .in2 (I2),
        .in3 (I3),
        .out (mux_y)
    );

    // Candidate winners: normal rotation from the pointer, and the timeout hand-off
    // which searches only the other requesters starting just after the owner.
    assign pick_ptr   = rr_pick(REQ, ptr_q);
    assign pick_other = rr_pick(REQ & ~onehot(s_q), s_q + 2'd1);
    assign owner_req  = REQ[s_q];

    // Next-state, grant, hold counter and data capture for one clock.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_ptr.found) begin
                    state_d = GRANT;
                    gnt_d   = onehot(pick_ptr.idx);
                    s_d     = pick_ptr.idx;
                    ptr_d   = pick_ptr.idx + 2'd1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    y_d     = mux_y;
                    valid_d = 1'b1;
                end
                if (!owner_req) begin
                    if (pick_ptr.found) begin
                        gnt_d = onehot(pick_ptr.idx);
                        s_d   = pick_ptr.idx;
                        ptr_d = pick_ptr.idx + 2'd1;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (pick_other.found) begin
                        gnt_d = onehot(pick_other.idx);
                        s_d   = pick_other.idx;
                        ptr_d = pick_other.idx + 2'd1;
                    end
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State register; reset wins over every other input, even mid-grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign GNT   = gnt_q;
    assign S     = s_q;
    assign Y     = y_q;
    assign VALID = valid_q;

endmodule
